multicycle_control: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle combinational control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, so the datapath can use a shared memory port and iterative MUL/DIV units.
- Adds ready/done handshakes with timeout, a latched exception cause, and a sticky halt state.
- Sits between the datapath (PC, IR, register file, ALU, memory interface) and the top level.

---
 rtl/cpu_defs_pkg.sv | 51 +++++
 rtl/ctrl_watchdog.sv | 30 +++
 rtl/multicycle_control.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Holds opcode/function-code constants, branch encodings, the controller
// state encoding (also exported on state_dbg) and exc_cause bit positions.
package cpu_defs;

    // Opcodes
    localparam logic [3:0] OpAlu  = 4'b0000;
    localparam logic [3:0] OpLw   = 4'b1000;
    localparam logic [3:0] OpSw   = 4'b1011;
    localparam logic [3:0] OpBlt  = 4'b0100;
    localparam logic [3:0] OpBgt  = 4'b0101;
    localparam logic [3:0] OpBeq  = 4'b0110;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpHalt = 4'b1111;

    // Function codes (also used directly as ALU selects)
    localparam logic [3:0] FnAdd = 4'b1111;
    localparam logic [3:0] FnSub = 4'b1110;
    localparam logic [3:0] FnAnd = 4'b1101;
    localparam logic [3:0] FnOr  = 4'b1100;
    localparam logic [3:0] FnMul = 4'b0001;
    localparam logic [3:0] FnDiv = 4'b0010;
    localparam logic [3:0] FnSll = 4'b1010;
    localparam logic [3:0] FnSlr = 4'b1011;
    localparam logic [3:0] FnRol = 4'b1001;
    localparam logic [3:0] FnRor = 4'b1000;

    // Branch selects
    localparam logic [1:0] BrNone = 2'b00;
    localparam logic [1:0] BrBeq  = 2'b01;
    localparam logic [1:0] BrBgt  = 2'b10;
    localparam logic [1:0] BrBlt  = 2'b11;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd7
    } state_t;

    // exc_cause bit positions
    localparam int unsigned ExcTimeout   = 5;
    localparam int unsigned ExcInvalidOp = 4;
    localparam int unsigned ExcInstMem   = 3;
    localparam int unsigned ExcDataMem   = 2;
    localparam int unsigned ExcAlu       = 1;
    localparam int unsigned ExcRegFile   = 0;

endpackage

// File: rtl/ctrl_watchdog.sv
// Handshake watchdog: counts cycles while enable is high, cleared by clear
// (takes priority) or reset. expired flags that the current cycle is the
// TIMEOUT_LIMIT-th consecutive wait cycle if enable is still high.
// Ports: clk, rst (sync, active-low), clear, enable, expired.
module ctrl_watchdog #(
    parameter int unsigned TIMEOUT_WIDTH = 8,
    parameter int unsigned TIMEOUT_LIMIT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + TIMEOUT_WIDTH'(1);
        end
    end

    // Count holds the number of wait cycles already spent, so the limit is
    // hit during the cycle whose count equals LIMIT-1.
    assign expired = (count_q == TIMEOUT_WIDTH'(TIMEOUT_LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handles memory/ALU handshakes with a watchdog,
// latches exception causes and parks in a sticky HALTED state.
// Inputs: clk, rst (sync, active-low), op_code/func_code from the IR,
//   inst_ready/data_ready/alu_done handshakes, exc_* datapath flags.
// Outputs: fetch/PC controls, branch/ALU selects, memory requests,
//   register write controls, halt, exc_cause, state_dbg.
module multicycle_control
    import cpu_defs::*;
#(
    parameter int unsigned OP_CODE_WIDTH        = 4,
    parameter int unsigned FUNCTION_CODE_WIDTH  = 4,
    parameter int unsigned ALU_CONTROL_WIDTH    = 4,
    parameter int unsigned BRANCH_CONTROL_WIDTH = 2,
    parameter int unsigned TIMEOUT_WIDTH        = 8,
    parameter int unsigned TIMEOUT_LIMIT        = 200
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OP_CODE_WIDTH-1:0]        op_code,
    input  logic [FUNCTION_CODE_WIDTH-1:0]  func_code,
    input  logic                            inst_ready,
    input  logic                            data_ready,
    input  logic                            alu_done,
    input  logic                            exc_inst_memory,
    input  logic                            exc_data_memory,
    input  logic                            exc_alu,
    input  logic                            exc_reg_file,
    output logic                            inst_rd,
    output logic                            ir_wr,
    output logic                            pc_inc,
    output logic                            jump,
    output logic [BRANCH_CONTROL_WIDTH-1:0] branch_control,
    output logic [ALU_CONTROL_WIDTH-1:0]    alu_control,
    output logic                            alu_a_src,
    output logic                            alu_b_src,
    output logic                            alu_start,
    output logic                            mem_rd,
    output logic                            mem_wrt,
    output logic                            write_reg,
    output logic                            write_r0,
    output logic                            reg_wr_src,
    output logic                            halt,
    output logic [5:0]                      exc_cause,
    output logic [2:0]                      state_dbg
);

    state_t     state_q, state_d;
    logic [5:0] cause_q, cause_d;
    logic       first_q;  // first cycle spent in the current state

    logic is_alu, is_lw, is_sw, is_blt, is_bgt, is_beq, is_jmp, is_halt;
    logic is_muldiv, is_shift, op_valid;
    logic waiting, expired, timeout, invalid_op, exc_any, kill;

    assign is_alu  = (op_code == OP_CODE_WIDTH'(OpAlu));
    assign is_lw   = (op_code == OP_CODE_WIDTH'(OpLw));
    assign is_sw   = (op_code == OP_CODE_WIDTH'(OpSw));
    assign is_blt  = (op_code == OP_CODE_WIDTH'(OpBlt));
    assign is_bgt  = (op_code == OP_CODE_WIDTH'(OpBgt));
    assign is_beq  = (op_code == OP_CODE_WIDTH'(OpBeq));
    assign is_jmp  = (op_code == OP_CODE_WIDTH'(OpJmp));
    assign is_halt = (op_code == OP_CODE_WIDTH'(OpHalt));
    assign op_valid = is_alu | is_lw | is_sw | is_blt | is_bgt | is_beq | is_jmp | is_halt;

    assign is_muldiv = is_alu && ((func_code == FUNCTION_CODE_WIDTH'(FnMul)) ||
                                  (func_code == FUNCTION_CODE_WIDTH'(FnDiv)));
    assign is_shift  = (func_code == FUNCTION_CODE_WIDTH'(FnSll)) ||
                       (func_code == FUNCTION_CODE_WIDTH'(FnSlr)) ||
                       (func_code == FUNCTION_CODE_WIDTH'(FnRol)) ||
                       (func_code == FUNCTION_CODE_WIDTH'(FnRor));

    // Kept outside the main decode block so the watchdog enable does not
    // depend on the next-state logic that consumes its expired flag.
    assign waiting = ((state_q == StFetch) && !inst_ready) ||
                     ((state_q == StExec) && is_muldiv && !alu_done) ||
                     ((state_q == StMem) && !data_ready);

    assign exc_any = exc_inst_memory | exc_data_memory | exc_alu | exc_reg_file;
    assign timeout = waiting && expired;
    assign kill    = !rst || (exc_any && (state_q != StHalted));

    ctrl_watchdog #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
        .TIMEOUT_LIMIT (TIMEOUT_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            cause_q <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            first_q <= (state_d != state_q);
        end
    end

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        invalid_op     = 1'b0;
        inst_rd        = 1'b0;
        ir_wr          = 1'b0;
        pc_inc         = 1'b0;
        jump           = 1'b0;
        branch_control = '0;
        alu_control    = '0;
        alu_a_src      = 1'b0;
        alu_b_src      = 1'b0;
        alu_start      = 1'b0;
        mem_rd         = 1'b0;
        mem_wrt        = 1'b0;
        write_reg      = 1'b0;
        write_r0       = 1'b0;
        reg_wr_src     = 1'b0;
        halt           = 1'b0;

        case (state_q)
            StFetch: begin
                inst_rd = 1'b1;
                if (inst_ready) begin
                    ir_wr   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!op_valid) begin
                    invalid_op = 1'b1;
                    state_d    = StHalted;
                end else if (is_halt) begin
                    state_d = StHalted;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_alu) begin
                    alu_control = ALU_CONTROL_WIDTH'(func_code);
                    alu_b_src   = is_shift;
                    if (is_muldiv) begin
                        alu_start = first_q;
                        if (alu_done) state_d = StWb;
                    end else begin
                        state_d = StWb;
                    end
                end else if (is_lw || is_sw) begin
                    alu_control = ALU_CONTROL_WIDTH'(FnAdd);
                    alu_a_src   = 1'b1;
                    state_d     = StMem;
                end else if (is_blt) begin
                    branch_control = BRANCH_CONTROL_WIDTH'(BrBlt);
                    state_d        = StFetch;
                end else if (is_bgt) begin
                    branch_control = BRANCH_CONTROL_WIDTH'(BrBgt);
                    state_d        = StFetch;
                end else if (is_beq) begin
                    branch_control = BRANCH_CONTROL_WIDTH'(BrBeq);
                    state_d        = StFetch;
                end else if (is_jmp) begin
                    jump    = 1'b1;
                    state_d = StFetch;
                end else begin
                    // IR changed under us; treat as an illegal instruction
                    invalid_op = 1'b1;
                    state_d    = StHalted;
                end
            end
            StMem: begin
                if (is_lw) begin
                    mem_rd      = 1'b1;
                    alu_a_src   = 1'b1;
                    alu_control = ALU_CONTROL_WIDTH'(FnAdd);
                    if (data_ready) state_d = StWb;
                end else begin
                    mem_wrt = 1'b1;
                    if (data_ready) state_d = StFetch;
                end
            end
            StWb: begin
                write_reg  = 1'b1;
                write_r0   = is_muldiv;
                reg_wr_src = is_lw;
                state_d    = StFetch;
            end
            StHalted: begin
                halt = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (state_q != StHalted) begin
            cause_d[ExcTimeout]   = cause_q[ExcTimeout]   | timeout;
            cause_d[ExcInvalidOp] = cause_q[ExcInvalidOp] | invalid_op;
            cause_d[ExcInstMem]   = cause_q[ExcInstMem]   | exc_inst_memory;
            cause_d[ExcDataMem]   = cause_q[ExcDataMem]   | exc_data_memory;
            cause_d[ExcAlu]       = cause_q[ExcAlu]       | exc_alu;
            cause_d[ExcRegFile]   = cause_q[ExcRegFile]   | exc_reg_file;
            if (timeout || invalid_op || exc_any) state_d = StHalted;
        end

        // Reset and same-cycle exceptions suppress every control pulse
        if (kill) begin
            inst_rd        = 1'b0;
            ir_wr          = 1'b0;
            pc_inc         = 1'b0;
            jump           = 1'b0;
            branch_control = '0;
            alu_control    = '0;
            alu_a_src      = 1'b0;
            alu_b_src      = 1'b0;
            alu_start      = 1'b0;
            mem_rd         = 1'b0;
            mem_wrt        = 1'b0;
            write_reg      = 1'b0;
            write_r0       = 1'b0;
            reg_wr_src     = 1'b0;
            halt           = 1'b0;
        end
    end

    assign state_dbg = rst ? state_q : 3'd0;
    assign exc_cause = rst ? cause_q : 6'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. The driver walks each instruction through
// its expected cycle-by-cycle trace (derived from instruction kind and wait
// counts) and queues the expected output vector for every cycle; a single
// compare process checks the DUT on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic       inst_rd, ir_wr, pc_inc, jump;
        logic [1:0] br;
        logic [3:0] alu;
        logic       a_src, b_src, start, mem_rd, mem_wrt, wreg, wr0, wsrc, halt;
        logic [5:0] cause;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4,
                           S_H = 3'd7;

    logic clk, rst;
    logic [3:0] op_code, func_code;
    logic inst_ready, data_ready, alu_done;
    logic exc_inst_memory, exc_data_memory, exc_alu, exc_reg_file;
    logic inst_rd, ir_wr, pc_inc, jump, alu_a_src, alu_b_src, alu_start;
    logic mem_rd, mem_wrt, write_reg, write_r0, reg_wr_src, halt;
    logic [1:0] branch_control;
    logic [3:0] alu_control;
    logic [5:0] exc_cause;
    logic [2:0] state_dbg;

    vec_t act;
    assign act = {inst_rd, ir_wr, pc_inc, jump, branch_control, alu_control, alu_a_src,
                  alu_b_src, alu_start, mem_rd, mem_wrt, write_reg, write_r0, reg_wr_src,
                  halt, exc_cause, state_dbg};

    multicycle_control dut (
        .clk             (clk),
        .rst             (rst),
        .op_code         (op_code),
        .func_code       (func_code),
        .inst_ready      (inst_ready),
        .data_ready      (data_ready),
        .alu_done        (alu_done),
        .exc_inst_memory (exc_inst_memory),
        .exc_data_memory (exc_data_memory),
        .exc_alu         (exc_alu),
        .exc_reg_file    (exc_reg_file),
        .inst_rd         (inst_rd),
        .ir_wr           (ir_wr),
        .pc_inc          (pc_inc),
        .jump            (jump),
        .branch_control  (branch_control),
        .alu_control     (alu_control),
        .alu_a_src       (alu_a_src),
        .alu_b_src       (alu_b_src),
        .alu_start       (alu_start),
        .mem_rd          (mem_rd),
        .mem_wrt         (mem_wrt),
        .write_reg       (write_reg),
        .write_r0        (write_r0),
        .reg_wr_src      (reg_wr_src),
        .halt            (halt),
        .exc_cause       (exc_cause),
        .state_dbg       (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vec_t  exp_q[$];
    string lbl_q[$];
    lit_t  lit_q[$];
    int    n_cmp = 0, n_bad = 0;
    int    n_start = 0, n_wr0 = 0, n_memrd = 0, n_memwrt = 0, n_jump = 0, n_fwait = 0;
    logic [5:0] cur_cause = '0;

    // Compare process: sole writer of the counters.
    initial begin
        forever begin
            @(negedge clk);
            while (lit_q.size() > 0) begin
                lit_t l;
                l = lit_q.pop_front();
                n_cmp++;
                if (l.act !== l.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0h expected %0h", l.name, l.act, l.exp);
                end
            end
            if (exp_q.size() > 0) begin
                vec_t  e;
                string s;
                e = exp_q.pop_front();
                s = lbl_q.pop_front();
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %07h expected %07h", s, $time, act, e);
                end
                n_start  += int'(act.start);
                n_wr0    += int'(act.wr0);
                n_memrd  += int'(act.mem_rd);
                n_memwrt += int'(act.mem_wrt);
                n_jump   += int'(act.jump);
                n_fwait  += int'(act.st == S_F && act.inst_rd && !act.ir_wr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    function automatic vec_t base(input logic [2:0] st);
        vec_t z;
        z       = '0;
        z.st    = st;
        z.cause = cur_cause;
        return z;
    endfunction

    function automatic bit op_defined(input logic [3:0] op);
        return op inside {4'b0000, 4'b1000, 4'b1011, 4'b0100, 4'b0101, 4'b0110,
                          4'b1100, 4'b1111};
    endfunction

    task automatic step(input string lbl, input vec_t e);
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
        lit_t l;
        l.name = name;
        l.act  = a;
        l.exp  = e;
        lit_q.push_back(l);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        inst_ready = 1'b1;  // must be ignored while in reset
        for (int i = 0; i < n; i++) step("reset", '0);
        rst = 1'b1;
        inst_ready = 1'b0;
        cur_cause = '0;
    endtask

    task automatic halted(input int n, input string lbl);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            inst_ready = 1'b1;
            exc_alu    = (i == 1);  // cause must stay frozen
            e = base(S_H);
            e.halt = 1'b1;
            step(lbl, e);
        end
        inst_ready = 1'b0;
        exc_alu    = 1'b0;
    endtask

    task automatic fetch_decode(input logic [3:0] op, input logic [3:0] fn, input int fw,
                                input string lbl);
        vec_t e;
        op_code   = op;
        func_code = fn;
        for (int i = 0; i < fw; i++) begin
            inst_ready = 1'b0;
            e = base(S_F);
            e.inst_rd = 1'b1;
            step({lbl, ".fwait"}, e);
        end
        inst_ready = 1'b1;
        e = base(S_F);
        e.inst_rd = 1'b1;
        e.ir_wr   = 1'b1;
        e.pc_inc  = 1'b1;
        step({lbl, ".fetch"}, e);
        inst_ready = 1'b0;
        step({lbl, ".decode"}, base(S_D));
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int fw,
                             input int xw, input int mw, input string lbl);
        vec_t e;
        bit   md;
        fetch_decode(op, fn, fw, lbl);
        if (!op_defined(op)) begin
            cur_cause[4] = 1'b1;
            return;
        end
        if (op == 4'b1111) return;
        md = (op == 4'b0000) && (fn == 4'b0001 || fn == 4'b0010);
        case (op)
            4'b0000: begin
                for (int i = 0; i <= (md ? xw : 0); i++) begin
                    alu_done = md && (i == xw);
                    e = base(S_E);
                    e.alu   = fn;
                    e.b_src = fn inside {4'b1010, 4'b1011, 4'b1001, 4'b1000};
                    e.start = md && (i == 0);
                    step({lbl, ".exec"}, e);
                end
                alu_done = 1'b0;
                e = base(S_W);
                e.wreg = 1'b1;
                e.wr0  = md;
                step({lbl, ".wb"}, e);
            end
            4'b1000, 4'b1011: begin
                e = base(S_E);
                e.alu   = 4'b1111;
                e.a_src = 1'b1;
                step({lbl, ".exec"}, e);
                for (int i = 0; i <= mw; i++) begin
                    data_ready = (i == mw);
                    e = base(S_M);
                    if (op == 4'b1000) begin
                        e.mem_rd = 1'b1;
                        e.a_src  = 1'b1;
                        e.alu    = 4'b1111;
                    end else begin
                        e.mem_wrt = 1'b1;
                    end
                    step({lbl, ".mem"}, e);
                end
                data_ready = 1'b0;
                if (op == 4'b1000) begin
                    e = base(S_W);
                    e.wreg = 1'b1;
                    e.wsrc = 1'b1;
                    step({lbl, ".wb"}, e);
                end
            end
            4'b0100, 4'b0101, 4'b0110: begin
                e = base(S_E);
                e.br = (op == 4'b0100) ? 2'b11 : (op == 4'b0101) ? 2'b10 : 2'b01;
                step({lbl, ".exec"}, e);
            end
            default: begin  // JMP
                e = base(S_E);
                e.jump = 1'b1;
                step({lbl, ".exec"}, e);
            end
        endcase
    endtask

    initial begin
        int   s0, w0, r0, m0, j0, f0;
        vec_t e;
        rst = 1'b0;
        op_code = '0;
        func_code = '0;
        inst_ready = 1'b0;
        data_ready = 1'b0;
        alu_done = 1'b0;
        exc_inst_memory = 1'b0;
        exc_data_memory = 1'b0;
        exc_alu = 1'b0;
        exc_reg_file = 1'b0;
        @(posedge clk);
        #1;

        do_reset(3);
        run_instr(4'b0000, 4'b1111, 0, 0, 0, "add");

        s0 = n_start;
        w0 = n_wr0;
        run_instr(4'b0000, 4'b0001, 0, 5, 0, "mul");
        lit("mul.start_pulses", 32'(n_start - s0), 32'd1);
        lit("mul.wr0_pulses", 32'(n_wr0 - w0), 32'd1);

        run_instr(4'b0000, 4'b1010, 2, 0, 0, "sll");
        run_instr(4'b0000, 4'b0010, 0, 0, 0, "div0");
        run_instr(4'b0000, 4'b1110, 0, 0, 0, "sub");

        r0 = n_memrd;
        run_instr(4'b1000, 4'b0000, 0, 0, 3, "lw");
        lit("lw.mem_rd_cycles", 32'(n_memrd - r0), 32'd4);

        m0 = n_memwrt;
        run_instr(4'b1011, 4'b0000, 0, 0, 0, "sw");
        lit("sw.mem_wrt_cycles", 32'(n_memwrt - m0), 32'd1);

        run_instr(4'b0110, 4'b0000, 0, 0, 0, "beq");
        j0 = n_jump;
        run_instr(4'b1100, 4'b0000, 0, 0, 0, "jmp");
        lit("jmp.jump_cycles", 32'(n_jump - j0), 32'd1);
        run_instr(4'b0100, 4'b0000, 0, 0, 0, "blt");
        run_instr(4'b0101, 4'b0000, 1, 0, 0, "bgt");

        // Undefined opcode
        run_instr(4'b0011, 4'b0000, 0, 0, 0, "inv");
        halted(3, "inv.halted");
        lit("inv.cause", 32'(exc_cause), 32'b010000);
        lit("inv.halt", 32'(halt), 32'd1);
        do_reset(1);

        // HALT instruction: no cause bits
        run_instr(4'b1111, 4'b0000, 0, 0, 0, "hlt");
        halted(2, "hlt.halted");
        lit("hlt.cause", 32'(exc_cause), 32'd0);
        do_reset(1);

        // Data-memory exception while SW waits in MEM
        fetch_decode(4'b1011, 4'b0000, 0, "swexc");
        e = base(S_E);
        e.alu = 4'b1111;
        e.a_src = 1'b1;
        step("swexc.exec", e);
        e = base(S_M);
        e.mem_wrt = 1'b1;
        step("swexc.mem", e);
        exc_data_memory = 1'b1;
        data_ready = 1'b1;  // exception wins over the handshake
        step("swexc.mem_exc", base(S_M));
        exc_data_memory = 1'b0;
        data_ready = 1'b0;
        cur_cause = 6'b000100;
        halted(2, "swexc.halted");
        lit("swexc.cause", 32'(exc_cause), 32'b000100);
        lit("swexc.mem_wrt", 32'(mem_wrt), 32'd0);
        do_reset(1);

        // Fetch timeout
        f0 = n_fwait;
        inst_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            e = base(S_F);
            e.inst_rd = 1'b1;
            step("tmo.fetch", e);
        end
        cur_cause = 6'b100000;
        halted(2, "tmo.halted");
        lit("tmo.fetch_cycles", 32'(n_fwait - f0), 32'd200);
        lit("tmo.cause", 32'(exc_cause), 32'b100000);
        do_reset(1);
        lit("rst.cause_cleared", 32'(exc_cause), 32'd0);

        // Reset in the middle of a MUL
        fetch_decode(4'b0000, 4'b0001, 0, "mulrst");
        e = base(S_E);
        e.alu = 4'b0001;
        e.start = 1'b1;
        step("mulrst.exec0", e);
        e.start = 1'b0;
        step("mulrst.exec1", e);
        do_reset(1);
        e = base(S_F);
        e.inst_rd = 1'b1;
        step("mulrst.fetch", e);
        run_instr(4'b0000, 4'b1101, 0, 0, 0, "and");

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
